// File: rtl/gearbox_32_33.sv
// gearbox_32_33: 32-bit to 33-bit LSB-first rate converter.
// RX side, between lane deserializer and 33-bit framing.
module gearbox_32_33 (
  input  logic        clk,
  input  logic        srst,
  input  logic [31:0] din,
  input  logic        din_valid,
  output logic        din_ready,
  output logic [32:0] dout,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic [6:0]  fill
);

  logic [63:0] storage;
  logic [63:0] storage_nxt;
  logic [6:0]  fill_nxt;
  logic [63:0] din_w;
  logic        acc;
  logic        pop;

  assign din_w      = {32'd0, din};
  assign dout_valid = (fill >= 7'd33);
  assign dout       = storage[32:0];
  // A same-cycle pop frees room, so dout_ready feeds straight through.
  assign din_ready  = !srst && ((fill <= 7'd32) || dout_ready);
  assign acc        = din_valid && din_ready;
  assign pop        = dout_valid && dout_ready;

  // Next storage/fill from the accept/pop combination.
  always_comb begin
    storage_nxt = storage;
    fill_nxt    = fill;
    unique case ({acc, pop})
      2'b01: begin
        storage_nxt = storage >> 33;
        fill_nxt    = fill - 7'd33;
      end
      2'b10: begin
        storage_nxt = storage | (din_w << fill);
        fill_nxt    = fill + 7'd32;
      end
      2'b11: begin
        storage_nxt = (storage >> 33)
                    | (din_w << (fill - 7'd33));
        fill_nxt    = fill - 7'd1;
      end
      default: begin
        storage_nxt = storage;
        fill_nxt    = fill;
      end
    endcase
  end

  // State register with synchronous clear.
  always_ff @(posedge clk) begin
    if (srst) begin
      storage <= '0;
      fill    <= '0;
    end else begin
      storage <= storage_nxt;
      fill    <= fill_nxt;
    end
  end

endmodule

// File: tb/tb_gearbox_32_33.sv
// tb_gearbox_32_33: directed and loopback checks
// for the 32-to-33 gearbox.
module tb_gearbox_32_33;

  logic        clk;
  logic        srst;
  logic [31:0] din;
  logic        din_valid;
  logic        din_ready;
  logic [32:0] dout;
  logic        dout_valid;
  logic        dout_ready;
  logic [6:0]  fill;

  int errors;
  int checks;
  int bubbles;
  int oidx;
  int idx;
  int cyc;

  logic [31:0] in_q[$];
  logic [32:0] exp_q[$];
  logic [32:0] src_q[$];
  bit          bq[$];

  logic [31:0] a_w;
  logic [31:0] b_w;
  logic [31:0] c_w;
  logic [32:0] hold_d;
  logic [32:0] w33;
  logic [31:0] w32;

  gearbox_32_33 dut (
    .clk        (clk),
    .srst       (srst),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .fill       (fill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    srst       = 1'b1;
    din_valid  = 1'b0;
    dout_ready = 1'b0;
    @(negedge clk);
    srst       = 1'b0;
  endtask

  // Bit-level repack of in_q (32-bit) into exp_q (33-bit).
  task automatic build_exp();
    bq.delete();
    exp_q.delete();
    foreach (in_q[i])
      for (int b = 0; b < 32; b++) bq.push_back(in_q[i][b]);
    while (bq.size() >= 33) begin
      for (int b = 0; b < 33; b++) w33[b] = bq.pop_front();
      exp_q.push_back(w33);
    end
  endtask

  // Stream in_q through the DUT, checking each popped word.
  task automatic run_stream(input bit rnd, input int limit);
    idx     = 0;
    oidx    = 0;
    cyc     = 0;
    bubbles = 0;
    while ((idx < in_q.size() || oidx < exp_q.size())
           && cyc < limit) begin
      @(negedge clk);
      din_valid  = (idx < in_q.size())
                && (!rnd || ($urandom_range(3) != 0));
      din        = din_valid ? in_q[idx] : $urandom;
      dout_ready = !rnd || ($urandom_range(2) != 0);
      #1;
      if (dout_valid && dout_ready) begin
        if (oidx < exp_q.size())
          chk("stream_word", 64'(dout), 64'(exp_q[oidx]));
        else
          chk("stream_extra", 64'(oidx), 64'(exp_q.size()));
        oidx++;
      end
      if (din_valid && din_ready) idx++;
      if (!rnd && !dout_valid && fill == 7'd32) bubbles++;
      cyc++;
    end
    @(negedge clk);
    din_valid  = 1'b0;
    dout_ready = 1'b0;
    chk("stream_timeout", 64'(cyc < limit), 64'd1);
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    srst       = 1'b1;
    din        = '0;
    din_valid  = 1'b0;
    dout_ready = 1'b0;

    // 1: reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout_valid", 64'(dout_valid), 64'd0);
    chk("rst_fill", 64'(fill), 64'd0);
    chk("rst_din_ready", 64'(din_ready), 64'd0);
    @(negedge clk);
    srst = 1'b0;
    #1;
    chk("rel_din_ready", 64'(din_ready), 64'd1);

    // 2: all-ones then all-zeros word
    @(negedge clk);
    din        = 32'hFFFF_FFFF;
    din_valid  = 1'b1;
    dout_ready = 1'b1;
    @(negedge clk);
    din = 32'h0000_0000;
    #1;
    chk("t2_fill32", 64'(fill), 64'd32);
    chk("t2_novalid", 64'(dout_valid), 64'd0);
    @(posedge clk);
    #1;
    chk("t2_valid", 64'(dout_valid), 64'd1);
    chk("t2_dout", 64'(dout), 64'h0_FFFF_FFFF);
    chk("t2_fill64", 64'(fill), 64'd64);
    @(negedge clk);
    din_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("t2_drop", 64'(dout_valid), 64'd0);
    chk("t2_fill31", 64'(fill), 64'd31);

    // 3: 33 back-to-back words
    do_reset();
    in_q.delete();
    for (int i = 0; i < 33; i++) in_q.push_back($urandom);
    build_exp();
    run_stream(1'b0, 200);
    chk("t3_beats", 64'(oidx), 64'd32);
    chk("t3_bubble", 64'(bubbles), 64'd1);
    #1;
    chk("t3_fill0", 64'(fill), 64'd0);

    // 4: full storage under backpressure
    do_reset();
    a_w = 32'hA5A5_0F0F;
    b_w = 32'h8000_0001;
    c_w = 32'h5555_AAAA;
    @(negedge clk);
    din        = a_w;
    din_valid  = 1'b1;
    dout_ready = 1'b0;
    @(negedge clk);
    din = b_w;
    @(negedge clk);
    din    = c_w;
    hold_d = {b_w[0], a_w};
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t4_fill64", 64'(fill), 64'd64);
      chk("t4_din_ready", 64'(din_ready), 64'd0);
      chk("t4_dout_hold", 64'(dout), 64'(hold_d));
      @(negedge clk);
    end
    dout_ready = 1'b1;
    #1;
    chk("t4_ready_up", 64'(din_ready), 64'd1);
    @(posedge clk);
    #1;
    chk("t4_fill63", 64'(fill), 64'd63);
    chk("t4_next", 64'(dout), 64'({c_w[1:0], b_w[31:1]}));

    // 5: loopback of random 33-bit words
    do_reset();
    src_q.delete();
    in_q.delete();
    bq.delete();
    for (int i = 0; i < 1024; i++) begin
      w33[31:0] = $urandom;
      w33[32]   = 1'($urandom_range(1));
      src_q.push_back(w33);
      for (int b = 0; b < 33; b++) bq.push_back(w33[b]);
    end
    while (bq.size() >= 32) begin
      for (int b = 0; b < 32; b++) w32[b] = bq.pop_front();
      in_q.push_back(w32);
    end
    exp_q = src_q;
    run_stream(1'b1, 20000);
    chk("t5_count", 64'(oidx), 64'd1024);
    #1;
    chk("t5_fill0", 64'(fill), 64'd0);

    // 6: reset mid-stream at fill 47
    do_reset();
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      din        = $urandom;
      din_valid  = 1'b1;
      dout_ready = 1'b1;
    end
    @(negedge clk);
    din_valid  = 1'b0;
    dout_ready = 1'b0;
    srst       = 1'b1;
    #1;
    chk("t6_fill47", 64'(fill), 64'd47);
    @(posedge clk);
    #1;
    chk("t6_fill0", 64'(fill), 64'd0);
    chk("t6_novalid", 64'(dout_valid), 64'd0);
    a_w = 32'h1357_9BDF;
    b_w = 32'hFEDC_BA99;
    @(negedge clk);
    srst      = 1'b0;
    din       = a_w;
    din_valid = 1'b1;
    @(negedge clk);
    din = b_w;
    #1;
    chk("t6_wait", 64'(dout_valid), 64'd0);
    @(posedge clk);
    #1;
    chk("t6_valid", 64'(dout_valid), 64'd1);
    chk("t6_dout", 64'(dout), 64'({b_w[0], a_w}));
    @(negedge clk);
    din_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
